dm_dump_tx: RTL
===============

# dm_dump_tx

Debug reader for the data memory. On a start pulse it reads `DUMP_LEN` consecutive bytes from a synchronous byte-wide memory read port, starting at a latched base address. It transmits each byte over a UART TX line as 8N1, LSB first. It sits beside the data memory on the board top and gives a serial view of memory contents alongside the seven-segment display, with no CPU involvement.

## Interface
Parameters:
- `CLK_DIV`, default 868: clocks per UART bit; 100 MHz / 115200. Legal values are ≥ 2.
- `ADDR_W`, default 10: memory byte-address width.
- `DUMP_LEN`, default 16: number of bytes sent per dump. Legal range is 1 to 2^ADDR_W.

Ports:
- `clk`, in, 1: system clock.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `start_i`, in, 1: dump request. Sampled only in IDLE.
- `base_addr_i`, in, ADDR_W: first byte address. Latched when `start_i` is accepted.
- `mem_en_o`, out, 1: memory read strobe, one cycle per byte.
- `mem_addr_o`, out, ADDR_W: memory read address.
- `mem_data_i`, in, 8: read data. Valid exactly one cycle after `mem_en_o`.
- `txd_o`, out, 1: UART serial output. Idles high.
- `busy_o`, out, 1: high from start acceptance until the last stop bit ends.
- `done_o`, out, 1: one-cycle pulse when a dump completes.
- `byte_cnt_o`, out, ADDR_W+1: bytes fully transmitted in the current or last dump.

## Operation
- Reset values: `txd_o`=1, `busy_o`=0, `done_o`=0, `mem_en_o`=0, `mem_addr_o`=0, `byte_cnt_o`=0. FSM is in IDLE and the bit-period counter is 0.
- FSM states:
  - IDLE: if `start_i`=1, latch `base_addr_i` into the address register, clear `byte_cnt_o`, set `busy_o`, go to FETCH.
  - FETCH: assert `mem_en_o` for one cycle with `mem_addr_o` = current address. Go to LATCH.
  - LATCH: capture `mem_data_i` into the shift register. Clear the bit counter and bit index. Go to START.
  - START: drive `txd_o`=0 for CLK_DIV cycles. Go to DATA.
  - DATA: drive `txd_o` = shift[0] for CLK_DIV cycles per bit, shifting right after each bit. After 8 bits go to STOP.
  - STOP: drive `txd_o`=1 for CLK_DIV cycles. At the end, increment `byte_cnt_o` and increment the address. If `byte_cnt_o`+1 = DUMP_LEN, go to IDLE and pulse `done_o`. Otherwise go to FETCH.
- Address arithmetic is modulo 2^ADDR_W; the address wraps from 2^ADDR_W−1 to 0.
- `mem_en_o` is high only in FETCH. `mem_addr_o` holds its last value outside FETCH.
- `txd_o` is high in IDLE, FETCH and LATCH, so inter-byte gaps are 2 idle-high cycles.
- `start_i` outside IDLE is ignored, with no queuing. `base_addr_i` changes after acceptance have no effect.
- `done_o` is asserted in the cycle the FSM is back in IDLE. A `start_i` in that same cycle is accepted, and `done_o` still pulses.
- `busy_o` drops in the same cycle `done_o` rises.
- Reset asserted mid-frame forces all outputs to reset values immediately, with no partial stop bit. The next dump requires a new `start_i`.

## Timing
- The start-accept edge puts the FSM in FETCH. `mem_en_o` is high in the first cycle after acceptance.
- The start bit begins 2 cycles after acceptance: `txd_o` first goes low in the 3rd cycle after the accepting edge.
- Each bit is exactly CLK_DIV cycles. One byte from FETCH entry to STOP end is 10·CLK_DIV + 2 cycles.
- A whole dump takes DUMP_LEN·(10·CLK_DIV + 2) cycles from the first FETCH to `done_o`.
- All outputs are registered, with no combinational path from input to output.

## Test plan
- Reset: hold `rstn`=0 with random inputs, then release. Required: `txd_o`=1, `busy_o`=0, `byte_cnt_o`=0, `mem_en_o`=0 until the first `start_i`.
- Single dump: CLK_DIV=4, DUMP_LEN=2, memory[5]=8'hA5, memory[6]=8'h3C, start with base 5. Required:
  - `mem_en_o` at addresses 5 then 6.
  - `txd_o` frames 0,1,0,1,0,0,1,0,1,1 and 0,0,0,1,1,1,1,0,0,1, each bit 4 cycles.
  - `done_o` pulses once, `byte_cnt_o`=2, 84 cycles from first FETCH.
- Wrap-around: ADDR_W=4, DUMP_LEN=3, base 14. Required: reads at 14, 15, 0.
- Ignored start: pulse `start_i` with base 9 mid-DATA of a dump at base 5. Required: addresses continue 5, 6, and no second dump follows.
- Back-to-back: `start_i` held high through the `done_o` cycle. Required: a new dump starts; `busy_o` low for exactly that one cycle; `done_o` pulses once per dump.
- Reset mid-frame: assert `rstn`=0 during DATA bit 3. Required: `txd_o`=1 and `busy_o`=0 immediately, and no further `mem_en_o` after release.

Source files
------------

// File: rtl/dm_dump_tx_if.sv
// Memory-read and serial-status bundle between dm_dump_tx and the board top.
// The master modport is the dump engine; slave is the memory/board side.
interface dm_dump_tx_if #(
  parameter int ADDR_W = 10
);
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic              mem_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_data_i;
  logic              txd_o;
  logic              busy_o;
  logic              done_o;
  logic [ADDR_W:0]   byte_cnt_o;

  modport master (
    input  start_i,
    input  base_addr_i,
    input  mem_data_i,
    output mem_en_o,
    output mem_addr_o,
    output txd_o,
    output busy_o,
    output done_o,
    output byte_cnt_o
  );

  modport slave (
    output start_i,
    output base_addr_i,
    output mem_data_i,
    input  mem_en_o,
    input  mem_addr_o,
    input  txd_o,
    input  busy_o,
    input  done_o,
    input  byte_cnt_o
  );
endinterface

// File: rtl/dm_dump_tx.sv
// Reads DUMP_LEN bytes from a sync memory port and sends each as a UART 8N1 frame.
// All outputs registered; start is only honoured in IDLE, nothing is queued.
module dm_dump_tx #(
  parameter int CLK_DIV  = 868,
  parameter int ADDR_W   = 10,
  parameter int DUMP_LEN = 16
) (
  input  logic         clk,
  input  logic         rstn,
  dm_dump_tx_if.master dm
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [ADDR_W:0] LEN_LAST = (ADDR_W + 1)'(DUMP_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [CW-1:0]     r_bit_cnt;
  logic [CW-1:0]     w_bit_cnt_nxt;
  logic [2:0]        r_bit_idx;
  logic [2:0]        w_bit_idx_nxt;
  logic [7:0]        r_shift;
  logic [7:0]        w_shift_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W:0]   r_byte_cnt;
  logic [ADDR_W:0]   w_byte_cnt_nxt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_en;
  logic              r_txd;
  logic              w_txd_nxt;
  logic              r_busy;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_bit_end;
  logic              w_last;

  assign w_bit_end = (r_bit_cnt == DIV_LAST);
  assign w_last    = (r_byte_cnt == LEN_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_addr_nxt     = r_addr;
    w_byte_cnt_nxt = r_byte_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_bit_cnt_nxt  = '0;
    w_done_nxt     = 1'b0;
    w_txd_nxt      = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (dm.start_i) begin
          w_state_nxt    = S_FETCH;
          w_addr_nxt     = dm.base_addr_i;
          w_byte_cnt_nxt = '0;
        end
      end
      S_FETCH: begin
        w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        w_state_nxt   = S_START;
        w_shift_nxt   = dm.mem_data_i;
        w_bit_idx_nxt = '0;
      end
      S_START: begin
        w_bit_cnt_nxt = w_bit_end ? '0 : r_bit_cnt + CW'(1);
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        w_bit_cnt_nxt = w_bit_end ? '0 : r_bit_cnt + CW'(1);
        if (w_bit_end) begin
          w_shift_nxt   = {1'b0, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        w_bit_cnt_nxt = w_bit_end ? '0 : r_bit_cnt + CW'(1);
        if (w_bit_end) begin
          w_byte_cnt_nxt = r_byte_cnt + (ADDR_W + 1)'(1);
          w_addr_nxt     = r_addr + ADDR_W'(1);
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Line level follows the state being entered so txd stays a plain flop.
    case (w_state_nxt)
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = w_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bit_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_addr     <= '0;
      r_byte_cnt <= '0;
      r_mem_addr <= '0;
      r_mem_en   <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_addr     <= w_addr_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_mem_en   <= (w_state_nxt == S_FETCH);
      r_txd      <= w_txd_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= w_done_nxt;
      // Read address only moves on a fetch, so it holds after the last byte.
      if (w_state_nxt == S_FETCH) begin
        r_mem_addr <= w_addr_nxt;
      end
    end
  end

  assign dm.mem_en_o   = r_mem_en;
  assign dm.mem_addr_o = r_mem_addr;
  assign dm.txd_o      = r_txd;
  assign dm.busy_o     = r_busy;
  assign dm.done_o     = r_done;
  assign dm.byte_cnt_o = r_byte_cnt;

endmodule
